// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iterative_unit_if.sv
// Issue/result bus between the EX-stage control and the multiply/divide unit.
interface muldiv_iterative_unit_if import muldiv_pkg::*; #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    muldiv_op_e      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, op, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, operand_a, operand_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on the {hi, lo} pair.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] m,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, m};
        hi_n    = sum[XLEN:1];
        lo_n    = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            // Partial remainder stays below the divisor, so bit XLEN of diff is the borrow.
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_iterative_unit.sv
// Iterative M-extension unit sharing one {hi, lo} datapath for multiply and divide.
// Optional MULDIV_EARLY_OUT_EN lets trivial multiplies/divides skip the CALC phase.
module muldiv_iterative_unit import muldiv_pkg::*; #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic                    clk,
    input logic                    rst,
    muldiv_iterative_unit_if.slave bus
);
    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    muldiv_state_e   state;
    muldiv_op_e      op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q, result_q;
    logic            neg_q, neg_r;

    muldiv_op_e      op_in;
    logic            sa, sb, is_div_in, div_zero, div_ovf, early, bypass;
    logic [XLEN-1:0] a, b, mag_a, mag_b, ld_hi, ld_lo, ld_m;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo, rem, fix_val;

    logic [XLEN-1:0] hi_c [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] lo_c [0:BITS_PER_CYCLE];

    // Issue decode: magnitudes, special cases and the initial {hi, lo, m} load.
    always_comb begin
        op_in     = bus.op;
        a         = bus.operand_a;
        b         = bus.operand_b;
        is_div_in = op_in[2];
        sa        = is_signed_a(op_in) & a[XLEN-1];
        sb        = is_signed_b(op_in) & b[XLEN-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
        div_zero  = is_div_in && (b == '0);
        div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early     = is_div_in ? (mag_a < mag_b) : ((a == '0) || (b == '0));
`else
        early     = 1'b0;
`endif
        bypass    = div_zero || div_ovf || early;
        ld_hi     = '0;
        ld_lo     = is_div_in ? mag_a : mag_b;
        ld_m      = is_div_in ? mag_b : mag_a;
        // Bypassed ops preload the final unsigned values so FIX passes them through.
        if (div_zero) begin
            ld_hi = a;
            ld_lo = '1;
        end else if (div_ovf) begin
            ld_lo = a;
        end else if (early) begin
            ld_hi = is_div_in ? a : '0;
            ld_lo = '0;
        end
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (op_q[2]),
            .m      (m_q),
            .hi     (hi_c[g]),
            .lo     (lo_c[g]),
            .hi_n   (hi_c[g+1]),
            .lo_n   (lo_c[g+1])
        );
    end

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo    = neg_q ? -lo_q : lo_q;
        rem    = neg_r ? -hi_q : hi_q;
        if (!op_q[2])
            fix_val = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else
            fix_val = op_q[1] ? rem : quo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.kill) begin
                    op_q  <= op_in;
                    hi_q  <= ld_hi;
                    lo_q  <= ld_lo;
                    m_q   <= ld_m;
                    neg_q <= bypass ? 1'b0 : (sa ^ sb);
                    neg_r <= bypass ? 1'b0 : sa;
                    cnt_q <= CNT_W'(N);
                    state <= bypass ? FIX : CALC;
                end
                CALC: if (bus.kill) begin
                    state <= IDLE;
                end else begin
                    hi_q  <= hi_c[BITS_PER_CYCLE];
                    lo_q  <= lo_c[BITS_PER_CYCLE];
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state <= FIX;
                end
                FIX: if (bus.kill) begin
                    state <= IDLE;
                end else begin
                    result_q <= fix_val;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Scoreboard bench for muldiv_iterative_unit with BITS_PER_CYCLE=1 and 4 instances side by side.
module tb_muldiv_iterative_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t q1[$];
    exp_t q4[$];
    logic [31:0] last1;

    muldiv_iterative_unit_if #(.XLEN(32)) bus1 ();
    muldiv_iterative_unit_if #(.XLEN(32)) bus4 ();

    muldiv_iterative_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    muldiv_iterative_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the next expected response whenever a done pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus1.done) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_result", bus1.result, e.res);
                check("dut1_done_cycle", 32'(cyc), 32'(e.cyc));
                check("dut1_busy_at_done", {31'd0, bus1.busy}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus4.done) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check("dut4_result", bus4.result, e.res);
                check("dut4_done_cycle", 32'(cyc), 32'(e.cyc));
                check("dut4_busy_at_done", {31'd0, bus4.busy}, 32'd1);
            end
        end
    end

    // Called on a falling edge (cycle 0); returns on the falling edge of cycle 1.
    task automatic issue(input int sel, input muldiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit push);
        exp_t e;
        e.res = exp;
        e.cyc = cyc + lat;
        if (sel == 1) begin
            bus1.op = op; bus1.operand_a = a; bus1.operand_b = b; bus1.start = 1'b1;
            if (push) begin q1.push_back(e); last1 = exp; end
        end else begin
            bus4.op = op; bus4.operand_a = a; bus4.operand_b = b; bus4.start = 1'b1;
            if (push) q4.push_back(e);
        end
        @(negedge clk);
        bus1.start = 1'b0;
        bus4.start = 1'b0;
        if (sel == 1) check("dut1_busy_cycle1", {31'd0, bus1.busy}, 32'd1);
        else          check("dut4_busy_cycle1", {31'd0, bus4.busy}, 32'd1);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (((sel == 1) ? bus1.busy : bus4.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic run(input int sel, input muldiv_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(sel, op, a, b, exp, lat, 1'b1);
        wait_idle(sel);
    endtask

    localparam int EO_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO1 = 2;
`else
    localparam int EO1 = EO_LAT;
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last1   = '0;
        rst     = 1'b0;
        bus1.start = 1'b0; bus1.kill = 1'b0; bus1.op = OP_MUL; bus1.operand_a = '0; bus1.operand_b = '0;
        bus4.start = 1'b0; bus4.kill = 1'b0; bus4.op = OP_MUL; bus4.operand_a = '0; bus4.operand_b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, bus1.busy}, 32'd0);
        check("reset_done", {31'd0, bus1.done}, 32'd0);
        check("reset_result", bus1.result, 32'd0);
        check("reset_busy4", {31'd0, bus4.busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run(1, OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run(1, OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 34);
        run(1, OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run(1, OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 34);
        run(1, OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 2);
        run(1, OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        2);
        run(1, OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2);
        run(1, OP_REMU,   32'd5,          32'd0,        32'd5,        2);
        run(1, OP_DIVU,   32'd100,        32'd7,        32'd14,       34);
        run(1, OP_MUL,    32'd0,          32'd9,        32'd0,        EO1);
        run(1, OP_DIVU,   32'd3,          32'd10,       32'd0,        EO1);
        run(1, OP_REM,    32'hFFFFFFFD,   32'd10,       32'hFFFFFFFD, EO1);
        run(1, OP_DIV,    32'd1000,       32'd3,        32'd333,      34);

        run(4, OP_REMU,   32'd100,        32'd7,        32'd2,        10);
        run(4, OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 10);
        run(4, OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 10);
        run(4, OP_MUL,    32'h12345678,   32'h10,       32'h23456780, 10);
        run(4, OP_DIVU,   32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 10);

        // Kill in cycle 5 of a divide: idle in cycle 6, no done pulse, result untouched.
        issue(1, OP_DIV, 32'd77, 32'd5, 32'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        bus1.kill = 1'b1;
        @(negedge clk);
        bus1.kill = 1'b0;
        check("kill_busy", {31'd0, bus1.busy}, 32'd0);
        check("kill_done", {31'd0, bus1.done}, 32'd0);
        check("kill_result", bus1.result, last1);
        repeat (40) @(negedge clk);
        check("kill_result_later", bus1.result, last1);

        // Start together with kill is dropped.
        bus1.op = OP_DIV; bus1.operand_a = 32'd9; bus1.operand_b = 32'd3;
        bus1.start = 1'b1; bus1.kill = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0; bus1.kill = 1'b0;
        check("start_kill_busy", {31'd0, bus1.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("start_kill_result", bus1.result, last1);

        // Asynchronous reset in the middle of CALC.
        issue(1, OP_MUL, 32'd7, 32'd3, 32'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, bus1.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus1.done}, 32'd0);
        check("async_rst_result", bus1.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
